// File: rtl/sdram_port_mux.sv
// SDRAM request stage: arbitrates chipset, CPU and refresh once per 7MHz bus slot and
// presents one request to the controller, with a regenerated sync strobe and per-port acks.
module sdram_port_mux #(
  parameter int REFRESH_SLOTS = 54,
  parameter int READ_DELAY    = 12,
  parameter int SLOT_LEN      = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_in_i,
  input  logic        chip_req_i,
  input  logic        chip_we_i,
  input  logic [21:0] chip_addr_i,
  input  logic [15:0] chip_din_i,
  input  logic [1:0]  chip_ds_i,
  output logic [15:0] chip_dout_o,
  output logic        chip_ack_o,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [21:0] cpu_addr_i,
  input  logic [15:0] cpu_din_i,
  input  logic [1:0]  cpu_ds_i,
  output logic [15:0] cpu_dout_o,
  output logic        cpu_ack_o,
  input  logic        ram_ready_i,
  output logic        ram_sync_o,
  output logic        ram_cs_o,
  output logic        ram_we_o,
  output logic        ram_refresh_o,
  output logic [21:0] ram_addr_o,
  output logic [15:0] ram_din_o,
  output logic [1:0]  ram_ds_o,
  input  logic [15:0] ram_dout_i
);

  // The slot stays BUSY until both the request window and the read capture are done.
  localparam int LAST  = (SLOT_LEN - 1 > READ_DELAY) ? SLOT_LEN - 1 : READ_DELAY;
  localparam int CNT_W = $clog2(LAST + 1);
  localparam int REF_W = $clog2(REFRESH_SLOTS);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {W_NONE, W_CHIP, W_CPU, W_REF} win_t;

  logic             sync_meta_q, sync_s_q, sync_s_d_q, ram_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_pend_q, ref_pend_d;
  logic [1:0]       defer_q, defer_d;
  win_t             win_q, win_d;
  logic             win_we_q, win_we_d;
  logic             ram_cs_q, ram_cs_d, ram_we_q, ram_we_d, ram_refresh_q, ram_refresh_d;
  logic [21:0]      ram_addr_q, ram_addr_d;
  logic [15:0]      ram_din_q, ram_din_d;
  logic [1:0]       ram_ds_q, ram_ds_d;
  logic             chip_ack_q, chip_ack_d, cpu_ack_q, cpu_ack_d;
  logic [15:0]      chip_dout_q, chip_dout_d, cpu_dout_q, cpu_dout_d;
  logic             rise, wrap, pend_now;

  assign rise     = sync_s_q & ~sync_s_d_q;
  assign wrap     = (ref_cnt_q == REF_W'(REFRESH_SLOTS - 1));
  assign pend_now = ref_pend_q | wrap;

  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q;
    ref_cnt_d     = ref_cnt_q;
    ref_pend_d    = ref_pend_q;
    defer_d       = defer_q;
    win_d         = win_q;
    win_we_d      = win_we_q;
    ram_cs_d      = ram_cs_q;
    ram_we_d      = ram_we_q;
    ram_refresh_d = ram_refresh_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    ram_ds_d      = ram_ds_q;
    chip_ack_d    = 1'b0;
    cpu_ack_d     = 1'b0;
    chip_dout_d   = chip_dout_q;
    cpu_dout_d    = cpu_dout_q;
    if (state_q == IDLE) begin
      if (rise && ram_ready_i) begin
        ref_cnt_d  = wrap ? '0 : ref_cnt_q + 1'b1;
        state_d    = BUSY;
        slot_cnt_d = '0;
        if (pend_now && defer_q >= 2'd2) win_d = W_REF;
        else if (chip_req_i)              win_d = W_CHIP;
        else if (pend_now)                win_d = W_REF;
        else if (cpu_req_i)               win_d = W_CPU;
        else                              win_d = W_NONE;
        ram_cs_d      = (win_d != W_NONE);
        ram_refresh_d = (win_d == W_REF);
        ram_we_d      = 1'b0;
        win_we_d      = 1'b0;
        if (win_d == W_REF) begin
          ref_pend_d = 1'b0;
          defer_d    = 2'd0;
        end else begin
          ref_pend_d = pend_now;
          defer_d    = !pend_now ? 2'd0 : (defer_q == 2'd3) ? defer_q : defer_q + 2'd1;
        end
        if (win_d == W_CHIP) begin
          ram_we_d   = chip_we_i;
          win_we_d   = chip_we_i;
          ram_addr_d = chip_addr_i;
          ram_din_d  = chip_din_i;
          ram_ds_d   = chip_ds_i;
        end else if (win_d == W_CPU) begin
          ram_we_d   = cpu_we_i;
          win_we_d   = cpu_we_i;
          ram_addr_d = cpu_addr_i;
          ram_din_d  = cpu_din_i;
          ram_ds_d   = cpu_ds_i;
        end
      end else if (rise) begin
        ram_cs_d = 1'b0;
      end
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
      if (slot_cnt_q == CNT_W'(SLOT_LEN - 1)) begin
        ram_cs_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_refresh_d = 1'b0;
      end
      // Registered ack/dout become visible during the slot_cnt==READ_DELAY cycle.
      if (slot_cnt_q == CNT_W'(READ_DELAY - 1)) begin
        if (win_q == W_CHIP) begin
          chip_ack_d = 1'b1;
          if (!win_we_q) chip_dout_d = ram_dout_i;
        end
        if (win_q == W_CPU) begin
          cpu_ack_d = 1'b1;
          if (!win_we_q) cpu_dout_d = ram_dout_i;
        end
      end
      if (slot_cnt_q == CNT_W'(LAST)) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta_q   <= 1'b0;
      sync_s_q      <= 1'b0;
      sync_s_d_q    <= 1'b0;
      ram_sync_q    <= 1'b0;
      state_q       <= IDLE;
      slot_cnt_q    <= '0;
      ref_cnt_q     <= '0;
      ref_pend_q    <= 1'b0;
      defer_q       <= 2'd0;
      win_q         <= W_NONE;
      win_we_q      <= 1'b0;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_refresh_q <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_ds_q      <= '0;
      chip_ack_q    <= 1'b0;
      cpu_ack_q     <= 1'b0;
      chip_dout_q   <= '0;
      cpu_dout_q    <= '0;
    end else begin
      sync_meta_q   <= sync_in_i;
      sync_s_q      <= sync_meta_q;
      sync_s_d_q    <= sync_s_q;
      ram_sync_q    <= sync_s_d_q;
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pend_q    <= ref_pend_d;
      defer_q       <= defer_d;
      win_q         <= win_d;
      win_we_q      <= win_we_d;
      ram_cs_q      <= ram_cs_d;
      ram_we_q      <= ram_we_d;
      ram_refresh_q <= ram_refresh_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_ds_q      <= ram_ds_d;
      chip_ack_q    <= chip_ack_d;
      cpu_ack_q     <= cpu_ack_d;
      chip_dout_q   <= chip_dout_d;
      cpu_dout_q    <= cpu_dout_d;
    end
  end

  assign ram_sync_o    = ram_sync_q;
  assign ram_cs_o      = ram_cs_q;
  assign ram_we_o      = ram_we_q;
  assign ram_refresh_o = ram_refresh_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_din_o     = ram_din_q;
  assign ram_ds_o      = ram_ds_q;
  assign chip_ack_o    = chip_ack_q;
  assign cpu_ack_o     = cpu_ack_q;
  assign chip_dout_o   = chip_dout_q;
  assign cpu_dout_o    = cpu_dout_q;

endmodule

// File: tb/tb_sdram_port_mux.sv
// Scenario bench for sdram_port_mux: 100MHz-style clk with a 16-clk bus sync period,
// expected acks queued at request time and popped when the DUT acknowledges.
module tb_sdram_port_mux;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_in_i = 1'b0;
  logic        chip_req_i = 1'b0, chip_we_i = 1'b0;
  logic [21:0] chip_addr_i = '0;
  logic [15:0] chip_din_i = '0;
  logic [1:0]  chip_ds_i = '0;
  logic [15:0] chip_dout_o;
  logic        chip_ack_o;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [21:0] cpu_addr_i = '0;
  logic [15:0] cpu_din_i = '0;
  logic [1:0]  cpu_ds_i = '0;
  logic [15:0] cpu_dout_o;
  logic        cpu_ack_o;
  logic        ram_ready_i = 1'b1;
  logic        ram_sync_o, ram_cs_o, ram_we_o, ram_refresh_o;
  logic [21:0] ram_addr_o;
  logic [15:0] ram_din_o;
  logic [1:0]  ram_ds_o;
  logic [15:0] ram_dout_i = '0;

  typedef struct {
    logic        is_cpu;
    logic [15:0] dout;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int rise_n = 0;
  int rise_base = 0;

  sdram_port_mux dut (
    .clk(clk), .reset_n(reset_n), .sync_in_i(sync_in_i),
    .chip_req_i(chip_req_i), .chip_we_i(chip_we_i), .chip_addr_i(chip_addr_i),
    .chip_din_i(chip_din_i), .chip_ds_i(chip_ds_i), .chip_dout_o(chip_dout_o),
    .chip_ack_o(chip_ack_o),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_din_i(cpu_din_i), .cpu_ds_i(cpu_ds_i), .cpu_dout_o(cpu_dout_o),
    .cpu_ack_o(cpu_ack_o),
    .ram_ready_i(ram_ready_i), .ram_sync_o(ram_sync_o), .ram_cs_o(ram_cs_o),
    .ram_we_o(ram_we_o), .ram_refresh_o(ram_refresh_o), .ram_addr_o(ram_addr_o),
    .ram_din_o(ram_din_o), .ram_ds_o(ram_ds_o), .ram_dout_i(ram_dout_i)
  );

  initial forever #5 clk = ~clk;

  // Bus sync: 16 clk period, edges land on clk falling edges.
  initial forever begin
    #80 sync_in_i = 1'b1;
    rise_n = rise_n + 1;
    #80 sync_in_i = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset released while sync_in is low so the first bus rise counted after release is rise 1.
  task automatic apply_reset;
    @(negedge sync_in_i);
    reset_n = 1'b0;
    chip_req_i = 1'b0;
    cpu_req_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rise_base = rise_n;
    exp_q.delete();
  endtask

  task automatic test_reset;
    logic [99:0] outs;
    @(negedge sync_in_i);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {ram_sync_o, ram_cs_o, ram_we_o, ram_refresh_o, ram_addr_o, ram_din_o, ram_ds_o,
            chip_ack_o, cpu_ack_o, chip_dout_o, cpu_dout_o};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_not_ready;
    int cs_seen = 0, acks = 0;
    apply_reset();
    ram_ready_i = 1'b0;
    cpu_addr_i = 22'h00042;
    cpu_req_i = 1'b1;
    repeat (48) begin
      @(negedge clk);
      if (ram_cs_o) cs_seen++;
      if (cpu_ack_o || chip_ack_o) acks++;
    end
    checks++;
    if (cs_seen !== 0) begin
      failures++;
      $display("FAIL not_ready_cs: got %0d cs cycles, want 0", cs_seen);
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL not_ready_ack: got %0d acks, want 0", acks);
    end
    cpu_req_i = 1'b0;
    ram_ready_i = 1'b1;
  endtask

  task automatic test_refresh;
    int cs_slots = 0, ref_slots = 0, first_rise = -1, acks = 0;
    logic prev_cs = 1'b0;
    apply_reset();
    repeat (60 * 16) begin
      @(negedge clk);
      if (ram_cs_o && !prev_cs) begin
        cs_slots++;
        if (ram_refresh_o && !ram_we_o) ref_slots++;
        if (first_rise < 0) first_rise = rise_n - rise_base;
      end
      prev_cs = ram_cs_o;
      if (chip_ack_o || cpu_ack_o) acks++;
    end
    checks++;
    if (cs_slots !== 1) begin
      failures++;
      $display("FAIL refresh_slots: got %0d cs slots, want 1", cs_slots);
    end
    checks++;
    if (ref_slots !== 1) begin
      failures++;
      $display("FAIL refresh_flag: got %0d refresh slots, want 1", ref_slots);
    end
    checks++;
    if (first_rise !== 54) begin
      failures++;
      $display("FAIL refresh_rise: got rise %0d, want 54", first_rise);
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL refresh_acks: got %0d acks, want 0", acks);
    end
  endtask

  task automatic test_cpu_read;
    int k = -1, cs_cnt = 0, ack_k = -1, acks = 0;
    logic hold_ok = 1'b1;
    exp_t e;
    apply_reset();
    ram_dout_i = 16'hBEEF;
    cpu_we_i = 1'b0;
    cpu_addr_i = 22'h12345;
    cpu_ds_i = 2'b00;
    cpu_req_i = 1'b1;
    exp_q.push_back('{1'b1, 16'hBEEF});
    repeat (60) begin
      @(negedge clk);
      if (k >= 0) k++;
      else if (ram_cs_o) k = 0;
      if (ram_cs_o) begin
        cs_cnt++;
        if (ram_addr_o !== 22'h12345 || ram_we_o !== 1'b0) hold_ok = 1'b0;
      end
      if (chip_ack_o || cpu_ack_o) begin
        acks++;
        ack_k = k;
        cpu_req_i = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cpu_read_sb: unexpected ack, queue empty");
        end else begin
          e = exp_q.pop_front();
          if (cpu_ack_o !== e.is_cpu || cpu_dout_o !== e.dout) begin
            failures++;
            $display("FAIL cpu_read_sb: got cpu_ack=%b dout=%h, want cpu_ack=%b dout=%h",
                     cpu_ack_o, cpu_dout_o, e.is_cpu, e.dout);
          end
        end
      end
    end
    checks++;
    if (cs_cnt !== 10 || hold_ok !== 1'b1) begin
      failures++;
      $display("FAIL cpu_read_hold: got %0d cycles ok=%b, want 10 ok=1", cs_cnt, hold_ok);
    end
    checks++;
    if (ack_k !== 12 || acks !== 1) begin
      failures++;
      $display("FAIL cpu_read_ack: got slot_cnt %0d count %0d, want 12 and 1", ack_k, acks);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL cpu_read_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int slot = 0, chip_acks = 0, cpu_acks = 0;
    logic [21:0] first_addr = '1;
    logic prev_cs = 1'b0;
    exp_t e;
    apply_reset();
    ram_dout_i = 16'h1234;
    chip_we_i = 1'b0;
    chip_addr_i = 22'h00AAA;
    cpu_we_i = 1'b0;
    cpu_addr_i = 22'h00BBB;
    exp_q.push_back('{1'b0, 16'h1234});
    exp_q.push_back('{1'b1, 16'h5678});
    chip_req_i = 1'b1;
    cpu_req_i = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (ram_cs_o && !prev_cs) begin
        slot++;
        if (slot == 1) first_addr = ram_addr_o;
      end
      prev_cs = ram_cs_o;
      if (chip_ack_o || cpu_ack_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL arb_sb: unexpected ack, queue empty");
        end else begin
          e = exp_q.pop_front();
          if (cpu_ack_o !== e.is_cpu || chip_ack_o !== !e.is_cpu ||
              (e.is_cpu ? cpu_dout_o : chip_dout_o) !== e.dout) begin
            failures++;
            $display("FAIL arb_sb: got chip_ack=%b cpu_ack=%b chip_dout=%h cpu_dout=%h, want cpu=%b dout=%h",
                     chip_ack_o, cpu_ack_o, chip_dout_o, cpu_dout_o, e.is_cpu, e.dout);
          end
        end
        if (chip_ack_o) begin
          chip_acks++;
          chip_req_i = 1'b0;
          ram_dout_i = 16'h5678;
        end
        if (cpu_ack_o) begin
          cpu_acks++;
          cpu_req_i = 1'b0;
        end
      end
    end
    checks++;
    if (first_addr !== 22'h00AAA) begin
      failures++;
      $display("FAIL arb_first: got addr %h, want 00aaa", first_addr);
    end
    checks++;
    if (chip_acks !== 1 || cpu_acks !== 1) begin
      failures++;
      $display("FAIL arb_acks: got chip=%0d cpu=%0d, want 1 and 1", chip_acks, cpu_acks);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL arb_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  // Runs straight after test_back_to_back so chip_dout holds 0x1234 from its read.
  task automatic test_chip_write;
    int cs_cnt = 0, acks = 0;
    logic hold_ok = 1'b1;
    exp_t e;
    ram_dout_i = 16'hDEAD;
    chip_we_i = 1'b1;
    chip_addr_i = 22'h03C3C;
    chip_din_i = 16'hA55A;
    chip_ds_i = 2'b01;
    exp_q.push_back('{1'b0, 16'h1234});
    chip_req_i = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (ram_cs_o) begin
        cs_cnt++;
        if (ram_we_o !== 1'b1 || ram_ds_o !== 2'b01 || ram_din_o !== 16'hA55A ||
            ram_addr_o !== 22'h03C3C) hold_ok = 1'b0;
      end
      if (chip_ack_o || cpu_ack_o) begin
        acks++;
        chip_req_i = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_sb: unexpected ack, queue empty");
        end else begin
          e = exp_q.pop_front();
          if (chip_ack_o !== 1'b1 || chip_dout_o !== e.dout) begin
            failures++;
            $display("FAIL write_sb: got chip_ack=%b chip_dout=%h, want 1 and %h",
                     chip_ack_o, chip_dout_o, e.dout);
          end
        end
      end
    end
    checks++;
    if (cs_cnt !== 10 || hold_ok !== 1'b1) begin
      failures++;
      $display("FAIL write_hold: got %0d cycles ok=%b, want 10 ok=1", cs_cnt, hold_ok);
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL write_acks: got %0d, want 1", acks);
    end
    chip_we_i = 1'b0;
  endtask

  task automatic test_refresh_defer;
    int cs_slots = 0, ref_slots = 0, ref_at = -1, chip_acks = 0;
    logic prev_cs = 1'b0;
    apply_reset();
    ram_dout_i = 16'h0F0F;
    chip_we_i = 1'b0;
    chip_addr_i = 22'h00111;
    chip_req_i = 1'b1;
    for (int c = 0; c < 2000 && (rise_n - rise_base) < 59; c++) begin
      @(negedge clk);
      if (ram_cs_o && !prev_cs) begin
        cs_slots++;
        if (ram_refresh_o) begin
          ref_slots++;
          ref_at = rise_n - rise_base;
        end
      end
      prev_cs = ram_cs_o;
      if (chip_ack_o) chip_acks++;
    end
    chip_req_i = 1'b0;
    checks++;
    if (ref_slots !== 1 || ref_at !== 56) begin
      failures++;
      $display("FAIL defer_refresh: got %0d refreshes at rise %0d, want 1 at 56", ref_slots, ref_at);
    end
    checks++;
    if (cs_slots !== 58 || chip_acks !== 57) begin
      failures++;
      $display("FAIL defer_chip: got slots=%0d acks=%0d, want 58 and 57", cs_slots, chip_acks);
    end
  endtask

  task automatic test_reset_mid;
    int k = -1, acks = 0;
    logic [99:0] outs;
    apply_reset();
    ram_dout_i = 16'h9999;
    cpu_we_i = 1'b0;
    cpu_addr_i = 22'h00777;
    cpu_req_i = 1'b1;
    for (int c = 0; c < 60 && k < 5; c++) begin
      @(negedge clk);
      if (k >= 0) k++;
      else if (ram_cs_o) k = 0;
    end
    checks++;
    if (k !== 5) begin
      failures++;
      $display("FAIL midreset_slot: got slot_cnt %0d, want 5", k);
    end
    reset_n = 1'b0;
    cpu_req_i = 1'b0;
    @(negedge clk);
    outs = {ram_sync_o, ram_cs_o, ram_we_o, ram_refresh_o, ram_addr_o, ram_din_o, ram_ds_o,
            chip_ack_o, cpu_ack_o, chip_dout_o, cpu_dout_o};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h, want 0", outs);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (chip_ack_o || cpu_ack_o) acks++;
    end
    checks++;
    if (acks !== 0 || cpu_dout_o !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_ack: got %0d acks dout=%h, want 0 and 0000", acks, cpu_dout_o);
    end
  endtask

  initial begin
    test_reset();
    test_not_ready();
    test_refresh();
    test_cpu_read();
    test_back_to_back();
    test_chip_write();
    test_refresh_defer();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
